fix_tx_scheduler: RTL and testbench
===================================

# fix_tx_scheduler

Arbitrates the single FIX message builder/transmit path between three requesters: the session controller (logon/logout/session replies), an internal heartbeat interval timer, and the business/application layer. Sits between the session controller and the message builder. Serialises one message at a time through initiate → created → sent, and generates a heartbeat whenever no message has been transmitted for HB_INTERVAL cycles while the session is open.

## Interface
- HB_INTERVAL, 1000: idle cycles (no completed send) before a heartbeat is scheduled; ≥2.
- STEP_TIMEOUT, 64: maximum cycles spent in WAIT_CREATE or WAIT_SENT; ≥2.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- session_open_i  in  1  logon accepted, session live; gates heartbeat and business grants.
- sess_req_i  in  1  session-level request; held until sess_ack_o or err_o.
- sess_type_i  in  3  message type for the session request; sampled at grant.
- biz_req_i  in  1  business/app request; held until biz_ack_o or err_o.
- message_created_i  in  1  builder finished the message (pulse).
- send_done_i  in  1  transmitter finished the message (pulse).
- create_message_o  out  3  type being built; valid from grant until return to IDLE.
- initiate_msg_o  out  1  one-cycle pulse that starts the builder.
- send_message_o  out  1  one-cycle pulse that starts transmission.
- sess_ack_o, biz_ack_o  out  1  one-cycle completion pulse to the owning requester.
- err_o  out  1  one-cycle pulse on a step timeout.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Type codes: LOGON 3'b001, HEARTBEAT 3'b010, LOGOUT 3'b100, BUSINESS 3'b111.
- All outputs are registered. Reset values are all 0, including create_message_o = 3'b000; the state is IDLE and the counters are 0.
- State machine:
  - IDLE → WAIT_CREATE on a grant.
  - WAIT_CREATE → WAIT_SENT on message_created_i.
  - WAIT_SENT → IDLE on send_done_i.
  - WAIT_CREATE or WAIT_SENT → IDLE on a step timeout.
- Grant priority, evaluated only in IDLE:
  - 1: sess_req_i.
  - 2: hb_pending && session_open_i.
  - 3: biz_req_i && session_open_i.
- On grant:
  - Latch the owner and type: sess_type_i, 3'b010 or 3'b111.
  - Drive create_message_o with the latched type and pulse initiate_msg_o.
  - Clear the step counter.
- message_created_i in WAIT_CREATE: pulse send_message_o and clear the step counter.
- send_done_i in WAIT_SENT:
  - Pulse the ack of the owner. Heartbeat owner: no ack.
  - Clear the heartbeat counter and hb_pending.
  - create_message_o returns to 0.
- message_created_i or send_done_i outside its wait state is ignored.
- Step timeout: the step counter reaches STEP_TIMEOUT−1 without the awaited pulse. Pulse err_o, issue no ack, return to IDLE, and leave the heartbeat counter unchanged. The requester may retry.
- Heartbeat counter:
  - Increments each cycle while session_open_i is high and saturates at HB_INTERVAL−1.
  - When it reaches HB_INTERVAL−1, set hb_pending.
  - session_open_i low clears the counter and hb_pending.
- Any completed send clears the heartbeat counter, because any outgoing traffic satisfies the FIX heartbeat rule.
- A requester deasserting before its ack is a protocol error; behaviour is undefined.

## Timing
- Request high in IDLE at cycle N: initiate_msg_o and create_message_o become valid at N+1, and busy_o is high from N+1.
- message_created_i at cycle M: send_message_o pulses at M+1.
- send_done_i at cycle K: ack pulses at K+1, and busy_o is low at K+1.
- The earliest new grant is sampled at K+1, so initiate_msg_o can fire at K+2. Minimum of 1 IDLE cycle between messages.
- A request arriving while busy waits; it is not dropped.
- Simultaneous sess_req_i and hb_pending: session wins. hb_pending stays set unless that session message completes, in which case it is cleared.
- message_created_i in the same cycle as the timeout threshold: the pulse wins and the FSM advances.
- rst mid-operation aborts immediately: no ack, no err_o, and all outputs are 0 on the next cycle.
- session_open_i falling mid-message does not abort the current message; it only blocks future heartbeat and business grants.

## Structure
- The type codes and the owner enum (OWN_SESS, OWN_HB, OWN_BIZ) belong in shared package fix_pkg, which the session controller and builder also use.
- Sub-module hb_timer holds the heartbeat counter and hb_pending:
  - Inputs: clk, rst, enable, clear.
  - Output: pending.
  - Parameter: HB_INTERVAL.
  - Counter width: $clog2(HB_INTERVAL).
- The arbiter FSM and step counter stay in the top module. Step counter width: $clog2(STEP_TIMEOUT).

## Test plan
- Logon: HB_INTERVAL=8, session_open_i=0. Assert sess_req_i with type 3'b001, then pulse created and done. Expected: initiate_msg_o 1 cycle after the request, create_message_o=001, send_message_o 1 cycle after created, sess_ack_o 1 cycle after done, no heartbeat issued.
- Heartbeat generation: HB_INTERVAL=8, session_open_i=1, no traffic. Expected: initiate_msg_o with create_message_o=010 issued 9 cycles after session_open_i rises. After done, the next heartbeat is initiated 9 cycles after that completion.
- Traffic suppresses heartbeats: business sends completing every 5 cycles. Expected: create_message_o is never 010.
- Priority: sess_req_i (type 100), biz_req_i and hb_pending all high in the same IDLE cycle. Expected:
  - Grant order is logout, then business; the heartbeat is cleared by the logout's completion and never sent.
  - sess_ack_o precedes biz_ack_o.
- Timeout: STEP_TIMEOUT=4, message_created_i withheld. Expected: err_o pulses, no ack, busy_o low, and the request is re-granted next IDLE.
- Reset mid-WAIT_SENT. Expected: all outputs 0 the next cycle, no ack or err_o, and the FSM starts in IDLE.

Source files
------------

// File: rtl/fix_pkg.sv
// fix_pkg: shared FIX message type codes, requester owners and scheduler states
package fix_pkg;
  localparam logic [2:0] TYPE_LOGON     = 3'b001;
  localparam logic [2:0] TYPE_HEARTBEAT = 3'b010;
  localparam logic [2:0] TYPE_LOGOUT    = 3'b100;
  localparam logic [2:0] TYPE_BUSINESS  = 3'b111;
  typedef enum logic [1:0] {OWN_SESS, OWN_HB, OWN_BIZ} owner_e;
  typedef enum logic [1:0] {IDLE, WAIT_CREATE, WAIT_SENT} state_e;
endpackage

// File: rtl/fix_tx_scheduler_hb_timer.sv
// hb_timer: counts open-session idle cycles and raises pending when a heartbeat is due
module hb_timer
  import fix_pkg::*;
#(
  parameter int HB_INTERVAL = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic pending
);
  localparam int W = $clog2(HB_INTERVAL);
  localparam logic [W-1:0] LAST = W'(HB_INTERVAL - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clear || !enable) begin
      cnt <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? cnt : cnt + 1'b1;
      pending <= pending || (cnt == LAST);
    end
endmodule

// File: rtl/fix_tx_scheduler.sv
// fix_tx_scheduler: arbitrates session, heartbeat and business messages onto one builder/transmit path
module fix_tx_scheduler
  import fix_pkg::*;
#(
  parameter int HB_INTERVAL  = 1000,
  parameter int STEP_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       session_open_i,
  input  logic       sess_req_i,
  input  logic [2:0] sess_type_i,
  input  logic       biz_req_i,
  input  logic       message_created_i,
  input  logic       send_done_i,
  output logic [2:0] create_message_o,
  output logic       initiate_msg_o,
  output logic       send_message_o,
  output logic       sess_ack_o,
  output logic       biz_ack_o,
  output logic       err_o,
  output logic       busy_o
);
  localparam int SW = $clog2(STEP_TIMEOUT);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TIMEOUT - 1);
  state_e state, state_n;
  owner_e owner, owner_n;
  logic [SW-1:0] step, step_n;
  logic [2:0] type_n;
  logic init_n, send_n, sack_n, back_n, err_n;
  logic hb_pending, grant_hb, grant_biz, timeout, sent;
  assign grant_hb  = hb_pending && session_open_i;
  assign grant_biz = biz_req_i && session_open_i;
  assign timeout   = step == STEP_LAST;
  assign sent      = state == WAIT_SENT && send_done_i;
  hb_timer #(.HB_INTERVAL(HB_INTERVAL)) u_hb_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (session_open_i),
    .clear  (sent),
    .pending(hb_pending)
  );
  always_comb begin
    state_n = state;
    owner_n = owner;
    step_n  = step + 1'b1;
    type_n  = create_message_o;
    init_n  = 1'b0;
    send_n  = 1'b0;
    sack_n  = 1'b0;
    back_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        step_n = '0;
        if (sess_req_i || grant_hb || grant_biz) begin
          state_n = WAIT_CREATE;
          owner_n = sess_req_i ? OWN_SESS : grant_hb ? OWN_HB : OWN_BIZ;
          type_n  = sess_req_i ? sess_type_i : grant_hb ? TYPE_HEARTBEAT : TYPE_BUSINESS;
          init_n  = 1'b1;
        end
      end
      WAIT_CREATE:
        if (message_created_i) begin
          state_n = WAIT_SENT;
          step_n  = '0;
          send_n  = 1'b1;
        end else if (timeout) begin
          state_n = IDLE;
          type_n  = '0;
          err_n   = 1'b1;
        end
      WAIT_SENT:
        if (send_done_i) begin
          state_n = IDLE;
          type_n  = '0;
          sack_n  = owner == OWN_SESS;
          back_n  = owner == OWN_BIZ;
        end else if (timeout) begin
          state_n = IDLE;
          type_n  = '0;
          err_n   = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state            <= IDLE;
      owner            <= OWN_SESS;
      step             <= '0;
      create_message_o <= '0;
      initiate_msg_o   <= 1'b0;
      send_message_o   <= 1'b0;
      sess_ack_o       <= 1'b0;
      biz_ack_o        <= 1'b0;
      err_o            <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      state            <= state_n;
      owner            <= owner_n;
      step             <= step_n;
      create_message_o <= type_n;
      initiate_msg_o   <= init_n;
      send_message_o   <= send_n;
      sess_ack_o       <= sack_n;
      biz_ack_o        <= back_n;
      err_o            <= err_n;
      busy_o           <= state_n != IDLE;
    end
endmodule

// File: tb/tb_fix_tx_scheduler.sv
// tb_fix_tx_scheduler: directed stimulus with a behavioural model compared every cycle
module tb_fix_tx_scheduler;
  import fix_pkg::*;
  localparam int HB = 8;
  localparam int ST = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic session_open_i = 1'b0, sess_req_i = 1'b0, biz_req_i = 1'b0;
  logic message_created_i = 1'b0, send_done_i = 1'b0;
  logic [2:0] sess_type_i = 3'b000;
  logic [2:0] create_message_o;
  logic initiate_msg_o, send_message_o, sess_ack_o, biz_ack_o, err_o, busy_o;
  int checks = 0, errors = 0, cyc = 0, tphase = 0;
  logic hb_seen = 1'b0;
  fix_tx_scheduler #(.HB_INTERVAL(HB), .STEP_TIMEOUT(ST)) dut (
    .clk              (clk),
    .rst              (rst),
    .session_open_i   (session_open_i),
    .sess_req_i       (sess_req_i),
    .sess_type_i      (sess_type_i),
    .biz_req_i        (biz_req_i),
    .message_created_i(message_created_i),
    .send_done_i      (send_done_i),
    .create_message_o (create_message_o),
    .initiate_msg_o   (initiate_msg_o),
    .send_message_o   (send_message_o),
    .sess_ack_o       (sess_ack_o),
    .biz_ack_o        (biz_ack_o),
    .err_o            (err_o),
    .busy_o           (busy_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  int m_phase = 0, m_who = 0, m_wait = 0, m_quiet = 0;
  logic [2:0] e_create = 3'b000;
  logic e_init = 0, e_send = 0, e_sack = 0, e_back = 0, e_err = 0, e_busy = 0;
  always @(posedge clk) begin : model
    logic due, done, awaited;
    e_init = 0; e_send = 0; e_sack = 0; e_back = 0; e_err = 0;
    if (rst) begin
      m_phase = 0; m_who = 0; m_wait = 0; m_quiet = 0; e_create = 3'b000; e_busy = 0;
    end else begin
      due = m_quiet >= HB;
      done = 0;
      if (m_phase == 0) begin
        if (sess_req_i) begin m_who = 1; e_create = sess_type_i; end
        else if (due && session_open_i) begin m_who = 2; e_create = 3'b010; end
        else if (biz_req_i && session_open_i) begin m_who = 3; e_create = 3'b111; end
        else m_who = 0;
        if (m_who != 0) begin m_phase = 1; m_wait = 0; e_init = 1; end
      end else begin
        awaited = (m_phase == 1) ? message_created_i : send_done_i;
        if (awaited && m_phase == 1) begin m_phase = 2; m_wait = 0; e_send = 1; end
        else if (awaited) begin
          m_phase = 0; done = 1; e_create = 3'b000; e_sack = m_who == 1; e_back = m_who == 3;
        end else if (m_wait == ST - 1) begin m_phase = 0; e_err = 1; e_create = 3'b000; end
        else m_wait++;
      end
      m_quiet = (done || !session_open_i) ? 0 : m_quiet + 1;
      e_busy = m_phase != 0;
    end
  end
  always @(negedge clk)
    if (cyc >= 1) begin
      check("create_message", create_message_o, e_create);
      check("initiate_msg", initiate_msg_o, e_init);
      check("send_message", send_message_o, e_send);
      check("sess_ack", sess_ack_o, e_sack);
      check("biz_ack", biz_ack_o, e_back);
      check("err", err_o, e_err);
      check("busy", busy_o, e_busy);
      if (tphase == 1 && create_message_o == 3'b010) hb_seen = 1'b1;
    end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      message_created_i = 1'b0;
      send_done_i = 1'b0;
    end
  endtask
  function automatic logic sig(input int sel);
    return sel == 0 ? initiate_msg_o : sel == 1 ? send_message_o : sel == 2 ? sess_ack_o :
           sel == 3 ? biz_ack_o : err_o;
  endfunction
  task automatic wait_sig(input int sel, input string name, output int at);
    at = -1;
    for (int n = 0; n < 40 && at < 0; n++) begin
      tick(1);
      if (sig(sel)) at = cyc;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: no pulse within 40 cycles", name);
    end
  endtask
  task automatic finish_msg(input int ack_sel, input string name, output int send_at, output int ack_at);
    message_created_i = 1'b1;
    wait_sig(1, name, send_at);
    send_done_i = 1'b1;
    send_at = cyc;
    wait_sig(ack_sel, name, ack_at);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int a, t0, d, s_at, b_at;
    tick(3);
    check("rst_busy", busy_o, 0);
    check("rst_create", create_message_o, 0);
    rst = 1'b0;
    tick(1);
    sess_type_i = 3'b001; sess_req_i = 1'b1; t0 = cyc;
    wait_sig(0, "logon_init", a);
    check("logon_init_lat", a - t0, 1);
    check("logon_type", create_message_o, 3'b001);
    check("logon_busy", busy_o, 1);
    message_created_i = 1'b1; t0 = cyc;
    wait_sig(1, "logon_send", a);
    check("logon_send_lat", a - t0, 1);
    send_done_i = 1'b1; t0 = cyc;
    wait_sig(2, "logon_ack", a);
    check("logon_ack_lat", a - t0, 1);
    check("logon_idle", busy_o, 0);
    sess_req_i = 1'b0;
    tick(12);
    check("logon_no_hb", busy_o, 0);
    session_open_i = 1'b1; t0 = cyc;
    wait_sig(0, "hb_init", a);
    check("hb_first_lat", a - t0, 9);
    check("hb_type", create_message_o, 3'b010);
    message_created_i = 1'b1;
    wait_sig(1, "hb_send", a);
    send_done_i = 1'b1; d = cyc;
    wait_sig(0, "hb2_init", a);
    check("hb_second_lat", a - (d + 1), 9);
    check("hb2_type", create_message_o, 3'b010);
    message_created_i = 1'b1;
    wait_sig(1, "hb2_send", a);
    send_done_i = 1'b1;
    tick(1);
    tphase = 1;
    for (int i = 0; i < 6; i++) begin
      biz_req_i = 1'b1;
      wait_sig(0, "biz_init", a);
      check("biz_type", create_message_o, 3'b111);
      finish_msg(3, "biz", d, a);
      biz_req_i = 1'b0;
      tick(2);
    end
    check("traffic_no_hb", hb_seen, 0);
    while (cyc < d + 9) tick(1);
    sess_type_i = 3'b100; sess_req_i = 1'b1; biz_req_i = 1'b1; t0 = cyc;
    wait_sig(0, "prio_init1", a);
    check("prio_lat", a - t0, 1);
    check("prio_first", create_message_o, 3'b100);
    finish_msg(2, "prio_sess", a, s_at);
    sess_req_i = 1'b0;
    wait_sig(0, "prio_init2", a);
    check("prio_second", create_message_o, 3'b111);
    check("prio_second_lat", a - s_at, 1);
    finish_msg(3, "prio_biz", a, b_at);
    biz_req_i = 1'b0;
    check("prio_order", s_at < b_at, 1);
    session_open_i = 1'b0;
    tick(2);
    tphase = 0;
    check("prio_no_hb", hb_seen, 0);
    sess_type_i = 3'b001; sess_req_i = 1'b1; t0 = cyc;
    wait_sig(0, "to_init", a);
    check("to_init_lat", a - t0, 1);
    wait_sig(4, "to_err", a);
    check("to_err_lat", a - t0, 5);
    check("to_busy", busy_o, 0);
    check("to_no_ack", sess_ack_o, 0);
    wait_sig(0, "to_regrant", a);
    check("to_regrant_lat", a - t0, 6);
    finish_msg(2, "to_retry", a, s_at);
    sess_req_i = 1'b0;
    tick(1);
    sess_type_i = 3'b100; sess_req_i = 1'b1;
    wait_sig(0, "rs_init", a);
    message_created_i = 1'b1;
    wait_sig(1, "rs_send", a);
    rst = 1'b1;
    tick(1);
    check("rs_create", create_message_o, 0);
    check("rs_send", send_message_o, 0);
    check("rs_ack", sess_ack_o, 0);
    check("rs_err", err_o, 0);
    check("rs_busy", busy_o, 0);
    rst = 1'b0; sess_req_i = 1'b0;
    tick(4);
    check("rs_idle", busy_o, 0);
    sess_type_i = 3'b001; sess_req_i = 1'b1; t0 = cyc;
    wait_sig(0, "rs_restart", a);
    check("rs_restart_lat", a - t0, 1);
    finish_msg(2, "rs_restart", a, s_at);
    sess_req_i = 1'b0;
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
